// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MUL_LAT_DEF = 4;

    // A load whose destination feeds either ID source must be held back one cycle.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: stage inputs and stage-register controls.
interface hazard_ctrl_if;
    logic       IDEX_MemRead_i;
    logic [4:0] IDEX_Rt_i;
    logic [4:0] IFID_Rs_i;
    logic [4:0] IFID_Rt_i;
    logic       branch_taken_i;
    logic       mul_start_i;

    logic       PC_write_o;
    logic       IFID_write_o;
    logic       IDEX_write_o;
    logic       IDEX_bubble_o;
    logic       EXMEM_bubble_o;
    logic       IFID_flush_o;
    logic       mul_busy_o;
    logic       mul_done_o;

    modport slave (
        input  IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, branch_taken_i, mul_start_i,
        output PC_write_o, IFID_write_o, IDEX_write_o, IDEX_bubble_o, EXMEM_bubble_o,
               IFID_flush_o, mul_busy_o, mul_done_o
    );

    modport master (
        output IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, branch_taken_i, mul_start_i,
        input  PC_write_o, IFID_write_o, IDEX_write_o, IDEX_bubble_o, EXMEM_bubble_o,
               IFID_flush_o, mul_busy_o, mul_done_o
    );
endinterface

// File: rtl/hazard_ctrl_mul_lat_cnt.sv
// Multiply-occupancy down-counter: loads a start value, decrements on request, flags zero.
module mul_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multiply stall > load-use stall > branch flush, outputs combinational.
// Multiply tracking is present only when HAZARD_MUL_EN is defined.
//
//   state    | meaning
//   RUN      | normal issue; load-use and branch flush resolved here, multiply may start
//   MUL_BUSY | multiply occupying EX; pipeline frozen until the counter reaches zero
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input logic         clk_i,
    input logic         rst_i,
    hazard_ctrl_if.slave bus
);
    logic hit;
    logic stall_mul;
    logic busy;
    logic done;
    logic bubble_id;
    logic flush;

    assign hit = load_use_hit(bus.IDEX_MemRead_i, bus.IDEX_Rt_i, bus.IFID_Rs_i, bus.IFID_Rt_i);

`ifdef HAZARD_MUL_EN
    localparam int               CNT_W    = $clog2(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

    state_e           state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_unused;

    mul_lat_cnt #(.W(CNT_W)) u_mul_lat_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_unused),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic       unused_mul_start;
    logic [4:0] unused_mul_lat;
    assign unused_mul_start = bus.mul_start_i;
    assign unused_mul_lat   = 5'(MUL_LAT);
`endif

    always_comb begin
        stall_mul = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        bubble_id = 1'b0;
        flush     = 1'b0;
`ifdef HAZARD_MUL_EN
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
`endif
        // Reset holds every output at its idle value, so no stale done pulse can escape.
        if (rst_i) begin
`ifdef HAZARD_MUL_EN
            if (state_q == MUL_BUSY) begin
                busy = 1'b1;
                if (cnt_zero) begin
                    done    = 1'b1;
                    state_d = RUN;
                end else begin
                    stall_mul = 1'b1;
                    cnt_dec   = 1'b1;
                end
            end else if (bus.mul_start_i) begin
                stall_mul = 1'b1;
                busy      = 1'b1;
                cnt_load  = 1'b1;
                state_d   = MUL_BUSY;
            end else
`endif
            if (hit) begin
                bubble_id = 1'b1;
            end else if (bus.branch_taken_i) begin
                flush = 1'b1;
            end
        end
    end

    assign bus.PC_write_o     = !(stall_mul || bubble_id);
    assign bus.IFID_write_o   = !(stall_mul || bubble_id);
    assign bus.IDEX_write_o   = !stall_mul;
    assign bus.IDEX_bubble_o  = bubble_id;
    assign bus.EXMEM_bubble_o = stall_mul;
    assign bus.IFID_flush_o   = flush;
    assign bus.mul_busy_o     = busy;
    assign bus.mul_done_o     = done;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow the HAZARD_MUL_EN setting of the build.
module tb_hazard_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (hz)
    );

    always #5 clk_i = ~clk_i;

    // {PC_write, IFID_write, IDEX_write, IDEX_bubble, EXMEM_bubble, IFID_flush, mul_busy, mul_done}
    localparam logic [7:0] NORMAL  = 8'b1110_0000;
    localparam logic [7:0] LOADUSE = 8'b0011_0000;
    localparam logic [7:0] FLUSH   = 8'b1110_0100;
`ifdef HAZARD_MUL_EN
    localparam logic [7:0] MSTALL  = 8'b0000_1010;
    localparam logic [7:0] MDONE   = 8'b1110_0011;
    localparam logic [7:0] BR_MUL  = 8'b0000_1010;
    localparam logic [7:0] LU_MUL  = 8'b0000_1010;
    localparam logic [7:0] ALL_MUL = 8'b0000_1010;
`else
    localparam logic [7:0] MSTALL  = NORMAL;
    localparam logic [7:0] MDONE   = NORMAL;
    localparam logic [7:0] BR_MUL  = FLUSH;
    localparam logic [7:0] LU_MUL  = LOADUSE;
    localparam logic [7:0] ALL_MUL = LOADUSE;
`endif

    function automatic logic [7:0] outs();
        return {hz.PC_write_o, hz.IFID_write_o, hz.IDEX_write_o, hz.IDEX_bubble_o,
                hz.EXMEM_bubble_o, hz.IFID_flush_o, hz.mul_busy_o, hz.mul_done_o};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs away from the rising edge, then compare outputs.
    task automatic cyc(input string tag, input logic mr, input logic [4:0] ex_rt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic mul, input logic [7:0] exp);
        @(negedge clk_i);
        hz.IDEX_MemRead_i = mr;
        hz.IDEX_Rt_i      = ex_rt;
        hz.IFID_Rs_i      = rs;
        hz.IFID_Rt_i      = rt;
        hz.branch_taken_i = br;
        hz.mul_start_i    = mul;
        #1;
        chk(tag, outs(), exp);
    endtask

    initial begin
        hz.IDEX_MemRead_i = 1'b0;
        hz.IDEX_Rt_i      = 5'd0;
        hz.IFID_Rs_i      = 5'd0;
        hz.IFID_Rt_i      = 5'd0;
        hz.branch_taken_i = 1'b0;
        hz.mul_start_i    = 1'b0;

        rst_i = 1'b0;
        cyc("rst_forced_mul", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, NORMAL);
        cyc("rst_forced_lu",  1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, NORMAL);
        rst_i = 1'b1;

        cyc("idle",           1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NORMAL);
        cyc("lu_rs",          1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, LOADUSE);
        cyc("lu_after",       1'b0, 5'd0, 5'd5, 5'd3, 1'b0, 1'b0, NORMAL);
        cyc("lu_rt",          1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, LOADUSE);
        cyc("lu_zero_reg",    1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, NORMAL);
        cyc("lu_no_memread",  1'b0, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, NORMAL);
        cyc("lu_no_match",    1'b1, 5'd31, 5'd30, 5'd29, 1'b0, 1'b0, NORMAL);
        cyc("branch",         1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, FLUSH);
        cyc("lu_and_branch",  1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, LOADUSE);
        cyc("branch_again",   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, FLUSH);

        cyc("mul_c1",         1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, MSTALL);
        cyc("mul_c2_branch",  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, BR_MUL);
        cyc("mul_c3_loaduse", 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, LU_MUL);
        cyc("mul_c4_done",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MDONE);
        cyc("mul_after",      1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NORMAL);

        cyc("mul_pri_c1",     1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, ALL_MUL);
        cyc("mul_pri_c2",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, MSTALL);
        cyc("mul_pri_c3",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MSTALL);
        cyc("mul_pri_c4",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MDONE);

        cyc("rmul_c1",        1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, MSTALL);
        cyc("rmul_c2",        1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, MSTALL);
        rst_i = 1'b0;
        cyc("rmul_c3_in_rst", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NORMAL);
        rst_i = 1'b1;
        cyc("rmul_no_done",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NORMAL);
        cyc("rmul_run_flush", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, FLUSH);
        cyc("rmul_restart",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, MSTALL);

        @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
